// File: rtl/alu_op_decoder.sv
// Single-slot RV32I OP/OP-IMM decoder for the ALU, with a valid/ready handshake on both sides.
// Optional feature macro: ILLEGAL_CNT_EN adds a saturating illegal_cnt output.
module alu_op_decoder #(
    parameter int          XLEN       = 32,
    parameter int          RA_W       = 5,
    parameter logic [3:0]  ILLEGAL_OP = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic [RA_W-1:0] rd,
    output logic            use_imm,
    output logic [XLEN-1:0] imm,
`ifdef ILLEGAL_CNT_EN
    output logic [15:0]     illegal_cnt,
`endif
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [3:0]      op_next;
    logic            use_imm_next;
    logic [XLEN-1:0] imm_next;
    logic            illegal_next;
    logic [RA_W-1:0] rs2_next;

    logic            valid_reg;
    logic [3:0]      op_reg;
    logic [RA_W-1:0] rs1_reg;
    logic [RA_W-1:0] rs2_reg;
    logic [RA_W-1:0] rd_reg;
    logic            use_imm_reg;
    logic [XLEN-1:0] imm_reg;
    logic            illegal_reg;
    logic            accept;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        op_next      = ILLEGAL_OP;
        use_imm_next = 1'b0;
        imm_next     = '0;
        illegal_next = 1'b1;
        if (instr[6:0] == OPC_OP) begin
            illegal_next = 1'b0;
            case ({funct7, funct3})
                {F7_BASE, 3'b000}: op_next = OP_ADD;
                {F7_BASE, 3'b001}: op_next = OP_SLL;
                {F7_BASE, 3'b010}: op_next = OP_SLT;
                {F7_BASE, 3'b011}: op_next = OP_SLTU;
                {F7_BASE, 3'b100}: op_next = OP_XOR;
                {F7_BASE, 3'b101}: op_next = OP_SRL;
                {F7_BASE, 3'b110}: op_next = OP_OR;
                {F7_BASE, 3'b111}: op_next = OP_AND;
                {F7_ALT,  3'b000}: op_next = OP_SUB;
                {F7_ALT,  3'b101}: op_next = OP_SRA;
                default:           illegal_next = 1'b1;
            endcase
        end else if (instr[6:0] == OPC_OP_IMM) begin
            illegal_next = 1'b0;
            use_imm_next = 1'b1;
            imm_next     = {{(XLEN-12){instr[31]}}, instr[31:20]};
            case (funct3)
                3'b000: op_next = OP_ADD;
                3'b010: op_next = OP_SLT;
                3'b011: op_next = OP_SLTU;
                3'b100: op_next = OP_XOR;
                3'b110: op_next = OP_OR;
                3'b111: op_next = OP_AND;
                3'b001: begin
                    imm_next = {{(XLEN-5){1'b0}}, instr[24:20]};
                    if (funct7 == F7_BASE) op_next = OP_SLL;
                    else                   illegal_next = 1'b1;
                end
                default: begin
                    imm_next = {{(XLEN-5){1'b0}}, instr[24:20]};
                    if (funct7 == F7_BASE)     op_next = OP_SRL;
                    else if (funct7 == F7_ALT) op_next = OP_SRA;
                    else                       illegal_next = 1'b1;
                end
            endcase
        end
        // Anything illegal is forwarded as a register-register ADD with no immediate
        if (illegal_next) begin
            op_next      = ILLEGAL_OP;
            use_imm_next = 1'b0;
            imm_next     = '0;
        end
    end

    assign rs2_next = use_imm_next ? '0 : instr[24:20];
    assign in_ready = ~flush & (~valid_reg | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            op_reg      <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            rd_reg      <= '0;
            use_imm_reg <= 1'b0;
            imm_reg     <= '0;
            illegal_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg   <= 1'b1;
            op_reg      <= op_next;
            rs1_reg     <= instr[19:15];
            rs2_reg     <= rs2_next;
            rd_reg      <= instr[11:7];
            use_imm_reg <= use_imm_next;
            imm_reg     <= imm_next;
            illegal_reg <= illegal_next;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

`ifdef ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_reg;

    // A flushed slot is discarded, so it never counts even if out_ready was high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt_reg <= '0;
        end else if (valid_reg && out_ready && !flush && illegal_reg
                     && illegal_cnt_reg != 16'hFFFF) begin
            illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
        end
    end

    assign illegal_cnt = illegal_cnt_reg;
`endif

    assign out_valid = valid_reg;
    assign alu_op    = op_reg;
    assign rs1       = rs1_reg;
    assign rs2       = rs2_reg;
    assign rd        = rd_reg;
    assign use_imm   = use_imm_reg;
    assign imm       = imm_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Table-driven bench for alu_op_decoder: expected records are queued on input handshakes
// and compared while the slot is presented downstream.
module tb_alu_op_decoder;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic        use_imm;
    logic [31:0] imm;
    logic        illegal;
`ifdef ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    vec_t sb[$];
    vec_t tbl[21];
    vec_t none;

    always #5 clk = ~clk;

    alu_op_decoder dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd),
        .use_imm(use_imm), .imm(imm),
`ifdef ILLEGAL_CNT_EN
        .illegal_cnt(illegal_cnt),
`endif
        .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the presented slot, update the scoreboard
    task automatic step(input logic v, input vec_t e, input logic ordy, input logic fl);
        bit accept;
        @(negedge clk);
        in_valid = v; instr = e.instr; out_ready = ordy; flush = fl;
        #1;
        accept = v && !fl && (sb.size() == 0 || ordy);
        chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, accept || (!fl && (sb.size() == 0 || ordy))});
        if (sb.size() != 0) begin
            if (fl) begin
                void'(sb.pop_front());
            end else begin
                chk("alu_op", {28'b0, alu_op}, {28'b0, sb[0].op});
                chk("rs1", {27'b0, rs1}, {27'b0, sb[0].rs1});
                chk("rs2", {27'b0, rs2}, {27'b0, sb[0].rs2});
                chk("rd", {27'b0, rd}, {27'b0, sb[0].rd});
                chk("use_imm", {31'b0, use_imm}, {31'b0, sb[0].use_imm});
                chk("imm", imm, sb[0].imm);
                chk("illegal", {31'b0, illegal}, {31'b0, sb[0].ill});
                if (ordy) begin
                    if (sb[0].ill && exp_cnt < 65535) exp_cnt++;
                    void'(sb.pop_front());
                end
            end
        end
        if (accept) sb.push_back(e);
    endtask

    task automatic reset_checks();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
        chk("rst_rd", {27'b0, rd}, 32'd0);
        chk("rst_rs1", {27'b0, rs1}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_use_imm", {31'b0, use_imm}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{32'h002081B3, 4'h0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // add
        tbl[1]  = '{32'h402081B3, 4'h1, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // sub
        tbl[2]  = '{32'hFFF00293, 4'h0, 5'd0, 5'd0, 5'd5, 1'b1, 32'hFFFFFFFF, 1'b0}; // addi -1
        tbl[3]  = '{32'h4033D313, 4'h9, 5'd7, 5'd0, 5'd6, 1'b1, 32'h3, 1'b0}; // srai
        tbl[4]  = '{32'h4033C313, 4'h6, 5'd7, 5'd0, 5'd6, 1'b1, 32'h403, 1'b0}; // xori
        tbl[5]  = '{32'h00000073, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1}; // ecall
        tbl[6]  = '{32'h0220C1B3, 4'h0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b1}; // funct7 0000001
        tbl[7]  = '{32'h002091B3, 4'h7, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // sll
        tbl[8]  = '{32'h0020A1B3, 4'h2, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // slt
        tbl[9]  = '{32'h0020B1B3, 4'h3, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // sltu
        tbl[10] = '{32'h0020C1B3, 4'h6, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // xor
        tbl[11] = '{32'h0020D1B3, 4'h8, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // srl
        tbl[12] = '{32'h4020D1B3, 4'h9, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // sra
        tbl[13] = '{32'h0020E1B3, 4'h5, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // or
        tbl[14] = '{32'h0020F1B3, 4'h4, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b0}; // and
        tbl[15] = '{32'h01F39313, 4'h7, 5'd7, 5'd0, 5'd6, 1'b1, 32'h1F, 1'b0}; // slli 31
        tbl[16] = '{32'h7FF0F293, 4'h4, 5'd1, 5'd0, 5'd5, 1'b1, 32'h7FF, 1'b0}; // andi max
        tbl[17] = '{32'h8000A293, 4'h2, 5'd1, 5'd0, 5'd5, 1'b1, 32'hFFFFF800, 1'b0}; // slti min
        tbl[18] = '{32'h002081B0, 4'h0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b1}; // low bits != 11
        tbl[19] = '{32'h402091B3, 4'h0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 1'b1}; // funct7 alt, sll
        tbl[20] = '{32'h0033D313, 4'h8, 5'd7, 5'd0, 5'd6, 1'b1, 32'h3, 1'b0}; // srli
        none = tbl[0];

        #2;
        reset_checks();
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream with downstream always ready
        for (int i = 0; i < 21; i++) step(1'b1, tbl[i], 1'b1, 1'b0);
        step(1'b0, none, 1'b1, 1'b0);
        step(1'b0, none, 1'b1, 1'b0);

        // Downstream stall for five cycles while new input waits
        step(1'b1, tbl[1], 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, tbl[2], 1'b0, 1'b0);
        step(1'b1, tbl[2], 1'b1, 1'b0);
        step(1'b0, none, 1'b1, 1'b0);
        step(1'b0, none, 1'b1, 1'b0);

        // Flush of a held slot; the instruction offered that cycle is dropped
        step(1'b1, tbl[3], 1'b0, 1'b0);
        step(1'b0, none, 1'b0, 1'b0);
        step(1'b1, tbl[4], 1'b1, 1'b1);
        step(1'b0, none, 1'b1, 1'b0);

        // Randomised traffic with random register fields and backpressure
        for (int i = 0; i < 120; i++) begin
            vec_t e;
            logic [4:0] r1, r2;
            e  = tbl[$urandom_range(0, 20)];
            r1 = 5'($urandom);
            r2 = 5'($urandom);
            e.instr[19:15] = r1;
            e.instr[11:7]  = r2;
            e.rs1 = r1;
            e.rd  = r2;
            step(1'($urandom), e, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        step(1'b0, none, 1'b1, 1'b0);
        step(1'b0, none, 1'b1, 1'b0);
`ifdef ILLEGAL_CNT_EN
        chk("illegal_cnt", {16'b0, illegal_cnt}, exp_cnt);
`endif

        // Asynchronous reset in the middle of a hold
        step(1'b1, tbl[17], 1'b1, 1'b0);
        step(1'b1, tbl[16], 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        reset_checks();
        sb.delete();
        exp_cnt = 0;
`ifdef ILLEGAL_CNT_EN
        chk("rst_illegal_cnt", {16'b0, illegal_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, tbl[6], 1'b1, 1'b0);
        step(1'b0, none, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
